// File: rtl/bot_viewport_sched_if.sv
// Bus between BOTSIM/video logic and the viewport scheduler.
// BOTSIM and video drive the master side; the scheduler is the slave.
interface bot_viewport_sched_if;
  logic        upd_sysregs;
  logic [7:0]  LocX_reg;
  logic [7:0]  LocY_reg;
  logic        frame_start;
  logic        snap;
  logic [10:0] vid_row;
  logic [10:0] vid_col;
  logic [10:0] map_row;
  logic [10:0] map_col;
  logic [7:0]  org_x;
  logic [7:0]  org_y;
  logic        scroll_busy;

  modport master (
    output upd_sysregs, LocX_reg, LocY_reg, frame_start, snap, vid_row, vid_col,
    input  map_row, map_col, org_x, org_y, scroll_busy
  );

  modport slave (
    input  upd_sysregs, LocX_reg, LocY_reg, frame_start, snap, vid_row, vid_col,
    output map_row, map_col, org_x, org_y, scroll_busy
  );
endinterface

// File: rtl/bot_viewport_sched.sv
// Viewport scheduler: follows the bot with a clamped window origin that moves only
// at frame boundaries, and offsets window-relative video coordinates into map addresses.
module bot_viewport_sched #(
  parameter int unsigned VIEW = 64,
  parameter int unsigned MAP  = 256,
  parameter int unsigned STEP = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  bot_viewport_sched_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, CALC, PEND} state_e;

  localparam logic signed [8:0] HALF    = 9'(VIEW / 2);
  localparam logic signed [8:0] MAX_ORG = 9'(MAP - VIEW);
  localparam logic signed [8:0] STEP_S  = 9'(STEP);

  state_e      state_q;
  logic [7:0]  loc_x_q, loc_y_q;
  logic [7:0]  tgt_x_q, tgt_y_q;
  logic [7:0]  org_x_q, org_y_q;
  logic [10:0] map_row_q, map_col_q;
  logic        scroll_busy_q;

  logic [7:0]  tgt_x_d, tgt_y_d;
  logic [7:0]  org_x_d, org_y_d;

  // Signed intermediate keeps loc - VIEW/2 from wrapping below zero.
  function automatic logic [7:0] clamp_org(input logic [7:0] loc);
    logic signed [8:0] d;
    d = $signed({1'b0, loc}) - HALF;
    if (d < 9'sd0)
      clamp_org = '0;
    else if (d > MAX_ORG)
      clamp_org = MAX_ORG[7:0];
    else
      clamp_org = d[7:0];
  endfunction

  function automatic logic [7:0] step_org(input logic [7:0] org, input logic [7:0] tgt);
    logic signed [8:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, org});
    if (d > STEP_S)
      step_org = org + STEP_S[7:0];
    else if (d < -STEP_S)
      step_org = org - STEP_S[7:0];
    else
      step_org = tgt;
  endfunction

  always_comb begin
    tgt_x_d = clamp_org(loc_x_q);
    tgt_y_d = clamp_org(loc_y_q);
    org_x_d = bus.snap ? tgt_x_q : step_org(org_x_q, tgt_x_q);
    org_y_d = bus.snap ? tgt_y_q : step_org(org_y_q, tgt_y_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      loc_x_q       <= '0;
      loc_y_q       <= '0;
      tgt_x_q       <= '0;
      tgt_y_q       <= '0;
      org_x_q       <= '0;
      org_y_q       <= '0;
      map_row_q     <= '0;
      map_col_q     <= '0;
      scroll_busy_q <= 1'b0;
    end else begin
      map_row_q     <= bus.vid_row + {3'b000, org_y_q};
      map_col_q     <= bus.vid_col + {3'b000, org_x_q};
      scroll_busy_q <= (tgt_x_q != org_x_q) || (tgt_y_q != org_y_q);

      unique case (state_q)
        CALC: begin
          // A new capture in CALC restarts it, so the stale target is not loaded.
          if (!bus.upd_sysregs) begin
            tgt_x_q <= tgt_x_d;
            tgt_y_q <= tgt_y_d;
            state_q <= ((tgt_x_d != org_x_q) || (tgt_y_d != org_y_q)) ? PEND : IDLE;
          end
        end
        PEND: begin
          if (bus.frame_start) begin
            org_x_q <= org_x_d;
            org_y_q <= org_y_d;
            state_q <= ((org_x_d == tgt_x_q) && (org_y_d == tgt_y_q)) ? IDLE : PEND;
          end
        end
        default: ;
      endcase

      // Capture wins the state from any state; a simultaneous step above still lands.
      if (bus.upd_sysregs) begin
        loc_x_q <= bus.LocX_reg;
        loc_y_q <= bus.LocY_reg;
        state_q <= CALC;
      end
    end
  end

  assign bus.map_row     = map_row_q;
  assign bus.map_col     = map_col_q;
  assign bus.org_x       = org_x_q;
  assign bus.org_y       = org_y_q;
  assign bus.scroll_busy = scroll_busy_q;

endmodule

// File: tb/tb_bot_viewport_sched.sv
// Directed bench for bot_viewport_sched with a cycle-level behavioural model.
module tb_bot_viewport_sched;

  localparam int VIEW = 64;
  localparam int MAP  = 256;
  localparam int STEP = 4;

  logic clk;
  logic reset;
  bot_viewport_sched_if bus ();

  bot_viewport_sched #(.VIEW(VIEW), .MAP(MAP), .STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: target appears two edges after a capture; stepping is allowed on a
  // frame_start when no capture landed on the previous edge and target != origin.
  function automatic int m_clamp(input int loc);
    int v;
    v = loc - VIEW / 2;
    if (v < 0) return 0;
    if (v > MAP - VIEW) return MAP - VIEW;
    return v;
  endfunction

  function automatic int m_step(input int org, input int tgt);
    int d;
    d = tgt - org;
    if (d > STEP) return org + STEP;
    if (d < -STEP) return org - STEP;
    return tgt;
  endfunction

  int m_ox, m_oy, m_tx, m_ty, m_px, m_py, m_cnt, m_row, m_col;
  bit m_busy;

  always @(posedge clk) begin
    if (reset) begin
      m_ox = 0; m_oy = 0; m_tx = 0; m_ty = 0; m_px = 0; m_py = 0;
      m_cnt = 0; m_row = 0; m_col = 0; m_busy = 1'b0;
    end else begin
      m_row  = (int'(bus.vid_row) + m_oy) % 2048;
      m_col  = (int'(bus.vid_col) + m_ox) % 2048;
      m_busy = (m_tx != m_ox) || (m_ty != m_oy);
      if (bus.frame_start && m_cnt == 0 && m_busy) begin
        m_ox = bus.snap ? m_tx : m_step(m_ox, m_tx);
        m_oy = bus.snap ? m_ty : m_step(m_oy, m_ty);
      end
      if (bus.upd_sysregs) begin
        m_px  = m_clamp(int'(bus.LocX_reg));
        m_py  = m_clamp(int'(bus.LocY_reg));
        m_cnt = 1;
      end else if (m_cnt == 1) begin
        m_tx  = m_px;
        m_ty  = m_py;
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("org_x", int'(bus.org_x), m_ox);
      check("org_y", int'(bus.org_y), m_oy);
      check("scroll_busy", int'(bus.scroll_busy), int'(m_busy));
      check("map_row", int'(bus.map_row), m_row);
      check("map_col", int'(bus.map_col), m_col);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic upd(input int x, input int y);
    bus.upd_sysregs = 1'b1;
    bus.LocX_reg    = 8'(x);
    bus.LocY_reg    = 8'(y);
    tick(1);
    bus.upd_sysregs = 1'b0;
  endtask

  task automatic frame(input bit s);
    bus.frame_start = 1'b1;
    bus.snap        = s;
    tick(1);
    bus.frame_start = 1'b0;
    bus.snap        = 1'b0;
    tick(3);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.upd_sysregs = 1'b0;
    bus.LocX_reg    = '0;
    bus.LocY_reg    = '0;
    bus.frame_start = 1'b0;
    bus.snap        = 1'b0;
    bus.vid_row     = '0;
    bus.vid_col     = '0;
    tick(2);
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    check("rst_org_x", int'(bus.org_x), 0);
    check("rst_busy", int'(bus.scroll_busy), 0);
    check("rst_map_row", int'(bus.map_row), 0);

    // Basic scroll toward (68,8); the frame during CALC must be ignored.
    upd(100, 40);
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
    tick(3);
    @(negedge clk);
    check("calc_frame_ignored", int'(bus.org_x), 0);
    check("busy_after_upd", int'(bus.scroll_busy), 1);
    for (int f = 1; f <= 20; f++) begin
      frame(1'b0);
      @(negedge clk);
      if (f == 2) begin
        check("f2_org_x", int'(bus.org_x), 8);
        check("f2_org_y", int'(bus.org_y), 8);
      end
      if (f == 16) check("f16_busy", int'(bus.scroll_busy), 1);
      if (f == 17) begin
        check("f17_org_x", int'(bus.org_x), 68);
        check("f17_busy", int'(bus.scroll_busy), 0);
      end
    end
    check("f20_org_x", int'(bus.org_x), 68);

    // Address path with origin (68,8).
    bus.vid_row = 11'd5;
    bus.vid_col = 11'd63;
    tick(1);
    @(negedge clk);
    check("addr_row", int'(bus.map_row), 13);
    check("addr_col", int'(bus.map_col), 131);
    tick(10);
    @(negedge clk);
    check("addr_row_hold", int'(bus.map_row), 13);
    check("addr_col_hold", int'(bus.map_col), 131);

    // Simultaneous capture and frame in PEND with org (60,8), tgt (68,8).
    pulse_reset();
    upd(100, 40);
    tick(3);
    repeat (15) frame(1'b0);
    @(negedge clk);
    check("pre_sim_org_x", int'(bus.org_x), 60);
    bus.upd_sysregs = 1'b1;
    bus.LocX_reg    = 8'd0;
    bus.LocY_reg    = 8'd0;
    bus.frame_start = 1'b1;
    tick(1);
    bus.upd_sysregs = 1'b0;
    bus.frame_start = 1'b0;
    @(negedge clk);
    check("sim_org_x", int'(bus.org_x), 64);
    check("sim_org_y", int'(bus.org_y), 8);
    tick(3);
    frame(1'b0);
    @(negedge clk);
    check("back_org_x", int'(bus.org_x), 60);
    check("back_org_y", int'(bus.org_y), 4);
    repeat (15) frame(1'b0);
    @(negedge clk);
    check("home_org_x", int'(bus.org_x), 0);
    check("home_busy", int'(bus.scroll_busy), 0);

    // Reset mid-scroll at org (40,0).
    upd(100, 32);
    tick(3);
    repeat (10) frame(1'b0);
    @(negedge clk);
    check("mid_org_x", int'(bus.org_x), 40);
    pulse_reset();
    @(negedge clk);
    check("mrst_org_x", int'(bus.org_x), 0);
    check("mrst_busy", int'(bus.scroll_busy), 0);
    check("mrst_map_col", int'(bus.map_col), 0);
    repeat (3) frame(1'b0);
    @(negedge clk);
    check("mrst_still", int'(bus.org_x), 0);

    // Edge clamps with snap, then no-op updates.
    upd(10, 250);
    tick(3);
    frame(1'b1);
    @(negedge clk);
    check("snap1_org_x", int'(bus.org_x), 0);
    check("snap1_org_y", int'(bus.org_y), 192);
    upd(224, 32);
    tick(3);
    frame(1'b1);
    @(negedge clk);
    check("snap2_org_x", int'(bus.org_x), 192);
    check("snap2_org_y", int'(bus.org_y), 0);
    upd(255, 0);
    tick(3);
    @(negedge clk);
    check("noop1_busy", int'(bus.scroll_busy), 0);
    upd(240, 20);
    tick(3);
    repeat (3) frame(1'b0);
    @(negedge clk);
    check("noop_org_x", int'(bus.org_x), 192);
    check("noop_org_y", int'(bus.org_y), 0);
    check("noop2_busy", int'(bus.scroll_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bot_viewport_sched.md
# bot_viewport_sched

Viewport scheduler between the BOTSIM location registers and the world-map video read port. It derives a 64×64 window origin on the 256×256 map from the bot's (LocX, LocY), clamped at map edges. The origin changes only at frame boundaries, by at most STEP locations per axis per frame, so the display never tears mid-frame and scrolling is smooth. It offsets the colorizer's window-relative vid_row/vid_col into absolute map addresses for the map's video port.

## Interface
- VIEW, 64: window size in map locations per axis, power of two, < MAP.
- MAP, 256: map size per axis.
- STEP, 4: maximum origin change per axis per frame, 1..255.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high; all state is cleared on the clock edge where it is sampled high.
- upd_sysregs  in  1  one-cycle pulse from BOTSIM; LocX/LocY are valid.
- LocX_reg  in  8  bot X location.
- LocY_reg  in  8  bot Y location.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- snap  in  1  when high at frame_start, the origin jumps straight to target.
- vid_row  in  11  window-relative row from video logic.
- vid_col  in  11  window-relative column from video logic.
- map_row  out  11  absolute map row to the map video port.
- map_col  out  11  absolute map column to the map video port.
- org_x  out  8  current window origin X.
- org_y  out  8  current window origin Y.
- scroll_busy  out  1  high while origin ≠ target.

## Operation
- Registers: loc_x/loc_y (latched location), tgt_x/tgt_y, org_x/org_y, map_row/map_col, state.
- States:
  - IDLE: origin = target.
  - CALC: one cycle; computes the target.
  - PEND: target ≠ origin; waits for frame_start.
- Capture: upd_sysregs high → loc_x/loc_y ← LocX_reg/LocY_reg, state → CALC. Applies from any state.
- CALC: tgt = clamp(loc − VIEW/2, 0, MAP−VIEW) per axis.
  - loc < VIEW/2 → 0.
  - loc > MAP−VIEW/2 → MAP−VIEW (192 with defaults).
  - Use 9-bit signed intermediate; no wrap.
  - Next state: PEND if tgt ≠ org, else IDLE.
- Stepping happens in PEND, on frame_start only. Per axis:
  - snap=1 → org ← tgt.
  - Otherwise, d = tgt − org; org ← org + sign(d)·min(|d|, STEP).
  - After the step: state → IDLE if org = tgt on both axes, else stays PEND.
- frame_start outside PEND has no effect. frame_start during CALC is ignored; stepping waits for the next frame.
- Simultaneous upd_sysregs and frame_start in PEND: the step uses the old tgt; the capture occurs and state → CALC.
- upd_sysregs while in CALC restarts CALC with the new location.
- Address path: map_row ← vid_row + org_y and map_col ← vid_col + org_x, both zero-extended 11-bit adds, modulo 2^11.
  - There is no window-range check; callers keep vid_row/vid_col < VIEW.
- scroll_busy = (tgt_x ≠ org_x) | (tgt_y ≠ org_y), registered.

## Timing
- Reset values: every output is 0; loc and tgt are 0; state is IDLE.
- Reset mid-scroll abandons the step immediately. The origin returns to (0,0).
- Capture → target valid: upd_sysregs at cycle n, loc latched at n+1, tgt valid and state settled at n+2.
- scroll_busy asserts at n+3.
- Origin changes only on the cycle after a frame_start sampled in PEND. org_x/org_y are constant between frame_starts.
- A 192-location jump at STEP=4 takes 48 frames.
- Address latency: map_row/map_col are registered, 1 cycle after vid_row/vid_col. The video pipeline accounts for this 1-cycle delay plus the map RAM read latency.
- Origin updates in blanking, so addresses within one frame all use the same origin.

## Test plan
- Reset, then LocX=100, LocY=40 with upd_sysregs, then 20 frame_starts → target (68,8). org_x steps by 4 per frame: 4, 8, … 68 after 17 frames. org_y reaches 8 after 2 frames. scroll_busy drops after frame 17.
- Edge clamp: Loc (10,250) with snap=1 at the first frame_start → org (0,192) in one frame; busy high one frame window only. Loc (224,32) → (192,0); Loc (255,0) → (192,0).
- Address path: org (68,8), vid_row=5, vid_col=63 → map_row=13 and map_col=131 one cycle later. Verify zero change to map_* while frame_start is absent.
- Simultaneous events: in PEND with tgt (68,8), org (60,8), pulse upd_sysregs (Loc 0,0) and frame_start together → org becomes (64,8). Target becomes (0,0) two cycles later. The next frames step org back down by 4.
- Reset mid-scroll: assert reset for one cycle while org = (40,0) and PEND → all outputs 0 next cycle, state IDLE. Further frame_starts cause no movement.
- No-op update: Loc giving tgt = current org → CALC → IDLE. scroll_busy never asserts; frame_starts leave org unchanged.
